muldiv_sequencer: RTL and testbench

- Iterative multiply/divide controller that executes MULT, MULTU, DIV and DIVU beside the single-cycle ALU, and owns the HI/LO register pair.
- EX stage issues an operation with a one-cycle start pulse. The pipeline stalls on busy and reads HI/LO for MFHI/MFLO.
- MTHI/MTLO write ports are also provided.
- One shift-add / shift-subtract step per cycle. The sign handling matches the ALU's signed/unsigned split.

---
 rtl/muldiv_sequencer.sv | 122 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Radix-2 shift-add multiply, restoring divide, sign fix-up on a final edge.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [1:0]         op_r;
    logic               sa, sb, dz;
    logic [WIDTH-1:0]   bm;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    logic             a_neg, b_neg, div_ok;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;

    assign a_neg     = ~op[0] & a[WIDTH-1];
    assign b_neg     = ~op[0] & b[WIDTH-1];
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? bm : {WIDTH{1'b0}})};
    // Remainder stays below the divisor, so the top bit of the trial is a pure borrow flag.
    assign div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, bm};
    assign div_ok    = ~div_trial[WIDTH];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (op[1] && b == '0) ? FIX : CALC;
            CALC: if (count == CW'(WIDTH-1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op;
                        sa    <= a_neg;
                        sb    <= b_neg;
                        count <= '0;
                        dz    <= op[1] && (b == '0);
                        rem   <= '0;
                        if (op[1]) begin
                            // Divide-by-zero keeps the raw dividend for HI.
                            bm   <= cond_neg(b, b_neg);
                            prod <= {{WIDTH{1'b0}}, (b == '0) ? a : cond_neg(a, a_neg)};
                        end else begin
                            bm   <= cond_neg(a, a_neg);
                            prod <= {{WIDTH{1'b0}}, cond_neg(b, b_neg)};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op_r[1]) begin
                        rem              <= div_ok ? div_trial : div_shift;
                        prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], div_ok};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (dz) begin
                        lo <= '1;
                        hi <= prod[WIDTH-1:0];
                    end else if (op_r[1]) begin
                        lo <= cond_neg(prod[WIDTH-1:0], sa ^ sb);
                        hi <= cond_neg(rem[WIDTH-1:0], sa);
                    end else begin
                        {hi, lo} <= cond_neg2(prod, sa ^ sb);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO queued at issue, popped on done.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int passed = 0;
    int total  = 0;
    logic [2*W-1:0] expq[$];

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued result.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h, expected no result", hi, lo);
                end else begin
                    e = expq.pop_front();
                    check("result_hi", hi, e[2*W-1:W]);
                    check("result_lo", lo, e[W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = ~x; b = y + 32'd3;
    endtask

    task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input int lat);
        int n, bc;
        expq.push_back({eh, el});
        issue(o, x, y);
        n = 0;
        bc = busy ? 1 : 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (busy) bc++;
        end
        check("latency", n, lat);
        check("busy_cycles", bc, lat);
        @(posedge clk); #1;
        check("done_pulse_end", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run(2'b00, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 33);
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 33);
        run(2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run(2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        33);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 33);
        run(2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1);

        // Start and MTHI while busy must be ignored.
        expq.push_back({32'd0, 32'd30});
        issue(2'b01, 32'd5, 32'd6);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (n == 9)  begin start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; end
            if (n == 10) start = 1'b0;
            if (n == 11) begin hi_we = 1'b1; wdata = 32'hAAAA; end
            if (n == 12) hi_we = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("busy_ignore_latency", n, 33);
        @(posedge clk); #1;
        check("busy_ignore_done_end", {31'd0, done}, 32'd0);

        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi", hi, 32'h55);
        check("mtlo", lo, 32'h55);

        // Reset mid-operation aborts without a result.
        issue(2'b00, 32'd3, 32'd4);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        run(2'b01, 32'd2, 32'd2, 32'd0, 32'd4, 33);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
